// File: rtl/rotation_servo_ctrl_pkg.sv
// Shared angle, direction and FSM definitions for the steering rotation controller.
// Types and constants only; no latency, no backpressure.
package rotation_servo_ctrl_pkg;

  localparam int ANGLE_MOD = 4096;
  localparam int ANGLE_W   = $clog2(ANGLE_MOD);

  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_RAMP_UP,
    ST_CRUISE,
    ST_RAMP_DOWN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rotation_servo_ctrl_shortest_path.sv
// Shortest wrap-around distance and direction between two angles (ties go CCW).
// Purely combinational, zero latency; no backpressure.
module rotation_servo_ctrl_shortest_path
  import rotation_servo_ctrl_pkg::*;
(
  input  logic [ANGLE_W-1:0] cur_i,
  input  logic [ANGLE_W-1:0] tgt_i,
  output logic [ANGLE_W-1:0] dist_o,
  output logic               dir_o
);

  logic [ANGLE_W-1:0] d_ccw;
  logic [ANGLE_W-1:0] d_cw;

  always_comb begin
    d_ccw = cur_i - tgt_i;
    d_cw  = tgt_i - cur_i;
    if (d_cw < d_ccw) begin
      dir_o  = DIR_CW;
      dist_o = d_cw;
    end else begin
      dir_o  = DIR_CCW;
      dist_o = d_ccw;
    end
  end

endmodule

// File: rtl/rotation_servo_ctrl.sv
// Steering rotation controller: ramped PWM duty plus direction toward a target angle.
// Latency: duty/dir one edge after CALC, arrival two edges after the encoder sample; no backpressure, abort always wins.
module rotation_servo_ctrl
  import rotation_servo_ctrl_pkg::*;
#(
  parameter int TOL       = 8,
  parameter int SLOW_ZONE = 256,
  parameter int MIN_DUTY  = 40,
  parameter int MAX_DUTY  = 255,
  parameter int RAMP_STEP = 1,
  parameter int RAMP_DIV  = 16,
  parameter int TIMEOUT   = 1 << 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [ANGLE_W-1:0] target_i,
  input  logic               abort_i,
  input  logic               angle_valid_i,
  input  logic [ANGLE_W-1:0] angle_i,
  output logic [7:0]         duty_o,
  output logic               dir_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ANGLE_W-1:0] TOL_C    = ANGLE_W'(TOL);
  localparam logic [ANGLE_W-1:0] SLOW_C   = ANGLE_W'(SLOW_ZONE);
  localparam logic [7:0]         MIN_C    = 8'(MIN_DUTY);
  localparam logic [7:0]         MAX_C    = 8'(MAX_DUTY);
  localparam logic [7:0]         STEP_C   = 8'(RAMP_STEP);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(RAMP_DIV - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic [ANGLE_W-1:0] tgt_q, tgt_d;
  logic [7:0]         duty_q, duty_d;
  logic               dir_q, dir_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;

  logic [ANGLE_W-1:0] sp_dist;
  logic               sp_dir;
  logic               near, slow, tick, tmo_hit, accept;
  logic [8:0]         up_sum;

  rotation_servo_ctrl_shortest_path u_sp (
    .cur_i  (angle_q),
    .tgt_i  (tgt_q),
    .dist_o (sp_dist),
    .dir_o  (sp_dir)
  );

  assign near    = (sp_dist <= TOL_C);
  assign slow    = (sp_dist <= SLOW_C);
  assign tick    = (pre_q == PRE_LAST);
  assign tmo_hit = (state_q != ST_IDLE) && (state_q != ST_DONE) && (tmo_q == TMO_LAST);
  assign accept  = (state_q == ST_IDLE) && start_i && !abort_i;
  assign up_sum  = {1'b0, duty_q} + {1'b0, STEP_C};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Arrival outranks the slow zone; timeout and abort outrank everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_i) state_d = ST_CALC;
      ST_CALC:      state_d = near ? ST_DONE : ST_RAMP_UP;
      ST_RAMP_UP: begin
        if (near)                                state_d = ST_DONE;
        else if (slow)                           state_d = ST_RAMP_DOWN;
        else if (tick && (up_sum >= {1'b0, MAX_C})) state_d = ST_CRUISE;
      end
      ST_CRUISE: begin
        if (near)      state_d = ST_DONE;
        else if (slow) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: if (near) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_IDLE;
    if (abort_i) state_d = ST_IDLE;
  end

  always_comb begin
    angle_d = angle_valid_i ? angle_i : angle_q;
    tgt_d   = accept ? target_i : tgt_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    pre_d   = (state_d != state_q || tick) ? '0 : pre_q + PRE_W'(1);
    tmo_d   = (state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
    err_d   = err_q;
    if (tmo_hit && !abort_i) err_d = 1'b1;
    if (accept)              err_d = 1'b0;

    if (state_d == ST_IDLE || state_d == ST_DONE) begin
      duty_d = '0;
    end else begin
      case (state_q)
        ST_CALC: begin
          duty_d = MIN_C;
          dir_d  = sp_dir;
        end
        ST_RAMP_UP: if (tick) duty_d = (up_sum >= {1'b0, MAX_C}) ? MAX_C : up_sum[7:0];
        ST_CRUISE:  duty_d = MAX_C;
        ST_RAMP_DOWN: begin
          if (tick) duty_d = ({1'b0, duty_q} < ({1'b0, MIN_C} + {1'b0, STEP_C})) ? MIN_C : duty_q - STEP_C;
          // Direction may only flip once the wheel has slowed to landing duty.
          if (duty_q == MIN_C) dir_d = sp_dir;
        end
        default: duty_d = duty_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle_q <= '0;
      tgt_q   <= '0;
      duty_q  <= '0;
      dir_q   <= DIR_CW;
      pre_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      angle_q <= angle_d;
      tgt_q   <= tgt_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      pre_q   <= pre_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_DONE);
    duty_o = duty_q;
    dir_o  = dir_q;
    err_o  = err_q;
  end

endmodule
